// File: rtl/mem_array_n.sv
// Word array with a 2-entry buffered write port and a bulk-clear sweep.
// All words are exposed in parallel for a downstream select mux.
module mem_array_n #(
  parameter int n       = 4,
  parameter int address = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [address-1:0] wr_addr_i,
  input  logic [n-1:0]       wr_data_i,
  input  logic               clr_i,
  output logic               busy_o,
  output logic               commit_valid_o,
  output logic [address-1:0] commit_addr_o,
  output logic [n-1:0]       data_o [0:2**address-1]
);

  localparam int m = 2**address;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state, state_nx;

  logic [address-1:0] clr_ptr;
  logic [address-1:0] addr0, addr1;
  logic [n-1:0]       dat0, dat1;
  logic [1:0]         count;
  logic               push, pop, wsel, last;

  assign wr_ready_o = (count != 2'd2);
  assign busy_o     = (state == CLEAR);
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = (state == IDLE) && (count != 2'd0);
  assign last       = &clr_ptr;
  // slot for an incoming write once the head has (maybe) left
  assign wsel       = count[0] && !pop;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // next state: clear starts only from idle, ends after the top word
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (clr_i) state_nx = CLEAR;
      CLEAR: if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // sweep pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
    end else if (clr_i) begin
      clr_ptr <= '0;
    end
  end

  // in-order two-entry write buffer; entry 0 is the head
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr0 <= '0;
      addr1 <= '0;
      dat0  <= '0;
      dat1  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        addr0 <= addr1;
        dat0  <= dat1;
      end
      if (push) begin
        if (wsel) begin
          addr1 <= wr_addr_i;
          dat1  <= wr_data_i;
        end else begin
          addr0 <= wr_addr_i;
          dat0  <= wr_data_i;
        end
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // array: sweep zeroes one word per cycle, otherwise head commits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < m; i++) data_o[i] <= '0;
    end else if (state == CLEAR) begin
      data_o[clr_ptr] <= '0;
    end else if (pop) begin
      data_o[addr0] <= dat0;
    end
  end

  // one-cycle commit report
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_valid_o <= 1'b0;
      commit_addr_o  <= '0;
    end else begin
      commit_valid_o <= pop;
      if (pop) commit_addr_o <= addr0;
    end
  end

endmodule

// File: tb/tb_mem_array_n.sv
// Bench for mem_array_n: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_mem_array_n;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int M  = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [AW-1:0] wr_addr_i = '0;
  logic [N-1:0]  wr_data_i = '0;
  logic          clr_i = 1'b0;
  logic          busy_o;
  logic          commit_valid_o;
  logic [AW-1:0] commit_addr_o;
  logic [N-1:0]  data_o [0:M-1];

  logic          v2 = 1'b0;
  logic          rdy2;
  logic [11:0]   a2 = '0;
  logic [N-1:0]  d2 = '0;
  logic          busy2;
  logic          cv2;
  logic [11:0]   ca2;
  logic [N-1:0]  data2 [0:4095];

  always #5 clk = ~clk;

  mem_array_n #(.n(N), .address(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .clr_i(clr_i), .busy_o(busy_o),
    .commit_valid_o(commit_valid_o), .commit_addr_o(commit_addr_o),
    .data_o(data_o)
  );

  mem_array_n #(.n(N), .address(12)) dut12 (
    .clk_i(clk), .rst_i(rst_i),
    .wr_valid_i(v2), .wr_ready_o(rdy2),
    .wr_addr_i(a2), .wr_data_i(d2),
    .clr_i(1'b0), .busy_o(busy2),
    .commit_valid_o(cv2), .commit_addr_o(ca2),
    .data_o(data2)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [N-1:0]  d;
  } wr_t;

  logic [N-1:0] ref_mem [M];
  wr_t          pend [$];
  int           clr_left;
  logic         exp_cv;
  logic [AW-1:0] exp_ca;
  int           total = 0;
  int           fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++) ref_mem[i] = '0;
    pend.delete();
    clr_left = 0;
    exp_cv = 1'b0;
    exp_ca = '0;
  endtask

  // one clock edge of the reference: sweep or drain one, then accept
  task automatic model_edge(input logic v, input logic [AW-1:0] a,
                            input logic [N-1:0] d, input logic c);
    wr_t e;
    bit acc;
    acc = v && (pend.size() < 2);
    exp_cv = 1'b0;
    if (clr_left > 0) begin
      ref_mem[M - clr_left] = '0;
      clr_left--;
    end else begin
      if (pend.size() > 0) begin
        e = pend.pop_front();
        ref_mem[e.a] = e.d;
        exp_cv = 1'b1;
        exp_ca = e.a;
      end
      if (c) clr_left = M;
    end
    if (acc) begin
      e.a = a;
      e.d = d;
      pend.push_back(e);
    end
  endtask

  task automatic check_array(input string tag);
    for (int i = 0; i < M; i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(data_o[i]), 32'(ref_mem[i]));
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a,
                      input logic [N-1:0] d, input logic c);
    @(negedge clk);
    wr_valid_i = v;
    wr_addr_i  = a;
    wr_data_i  = d;
    clr_i      = c;
    #1;
    chk("ready", 32'(wr_ready_o), 32'(pend.size() != 2));
    chk("busy", 32'(busy_o), 32'(clr_left > 0));
    @(posedge clk);
    model_edge(v, a, d, c);
    #1;
    chk("commit_valid", 32'(commit_valid_o), 32'(exp_cv));
    if (exp_cv) chk("commit_addr", 32'(commit_addr_o), 32'(exp_ca));
    check_array("data");
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  // asynchronous reset raised mid-cycle, checked before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_i = 1'b1;
    wr_valid_i = 1'b0;
    clr_i = 1'b0;
    v2 = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", 32'(wr_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cv", 32'(commit_valid_o), 32'd0);
    chk("rst_ca", 32'(commit_addr_o), 32'd0);
    check_array("rst");
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // single write
    step(1'b1, 4'd5, 4'hA, 1'b0);
    idle(3);

    // back-to-back, same address twice
    step(1'b1, 4'd3, 4'h1, 1'b0);
    step(1'b1, 4'd3, 4'h2, 1'b0);
    step(1'b1, 4'd7, 4'h9, 1'b0);
    idle(3);
    chk("last_wins", 32'(data_o[3]), 32'h2);

    // async reset with populated array
    do_reset();

    // fill, then clear with writes during the sweep
    for (int i = 0; i < M; i++) step(1'b1, AW'(i), 4'hF, 1'b0);
    idle(2);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 4'd2, 4'h6, 1'b0);
    step(1'b1, 4'd9, 4'h3, 1'b0);
    step(1'b1, 4'd4, 4'h4, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    idle(16);
    chk("survive2", 32'(data_o[2]), 32'h6);
    chk("survive9", 32'(data_o[9]), 32'h3);

    // clear coinciding with an accept in idle
    step(1'b1, 4'd4, 4'h7, 1'b1);
    idle(19);
    chk("survive4", 32'(data_o[4]), 32'h7);

    // reset mid-sweep with two writes buffered
    for (int i = 0; i < M; i++) step(1'b1, AW'(i), AW'(i), 1'b0);
    idle(2);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 4'd1, 4'h8, 1'b0);
    step(1'b1, 4'd2, 4'h8, 1'b0);
    idle(4);
    do_reset();
    idle(3);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), AW'($urandom), N'($urandom),
           ($urandom_range(0, 24) == 0));
    idle(20);

    // full-size array read back through a select index
    @(negedge clk);
    v2 = 1'b1;
    a2 = 12'hABC;
    d2 = 4'h5;
    @(negedge clk);
    v2 = 1'b0;
    @(posedge clk);
    #1;
    begin
      logic [11:0] sel;
      sel = 12'hABC;
      chk("mux_sel_hit", 32'(data2[sel]), 32'h5);
      sel = 12'h123;
      chk("mux_sel_zero", 32'(data2[sel]), 32'h0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
